// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the Simple RISC datapath controller: FSM states,
// instruction fields, instruction classes and datapath select codes.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_RD_A   = 3'd3,
    S_RD_B   = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_RES = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_MOV_IMM = 3'd0,
    CL_MOV_REG = 3'd1,
    CL_ALU2    = 3'd2,
    CL_CMP     = 3'd3,
    CL_MVN     = 3'd4,
    CL_ILLEGAL = 3'd5
  } instr_class_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // MOV reg and MVN pass B straight through the ALU, so A is forced to zero.
  function automatic logic class_zero_a(input instr_class_t cls);
    return (cls == CL_MOV_REG) || (cls == CL_MVN);
  endfunction

  function automatic logic class_sets_flags(input instr_class_t cls);
    return (cls == CL_CMP);
  endfunction

endpackage

// File: rtl/risc_instr_class.sv
// Combinational classifier: maps the {opcode, op} instruction fields onto
// the small set of instruction classes the controller sequences.
module risc_instr_class
  import risc_ctrl_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_op,
  output logic [2:0] o_class
);

  instr_class_t w_class;

  always_comb begin
    w_class = CL_ILLEGAL;
    if (i_opcode == OPC_MOV) begin
      if (i_op == OP_MOV_IMM)      w_class = CL_MOV_IMM;
      else if (i_op == OP_MOV_REG) w_class = CL_MOV_REG;
      else                         w_class = CL_ILLEGAL;
    end else if (i_opcode == OPC_ALU) begin
      case (i_op)
        OP_ADD:  w_class = CL_ALU2;
        OP_AND:  w_class = CL_ALU2;
        OP_CMP:  w_class = CL_CMP;
        OP_MVN:  w_class = CL_MVN;
        default: w_class = CL_ILLEGAL;
      endcase
    end
  end

  assign o_class = w_class;

endmodule

// File: rtl/risc_datapath_ctrl.sv
// Moore control FSM for the Simple RISC datapath: one instruction per start
// pulse, issuing the register-file and A/B/C/status load strobes in order.
module risc_datapath_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int VSEL_W = 2,
  parameter int NSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  output logic              w,
  output logic [NSEL_W-1:0] nsel,
  output logic [VSEL_W-1:0] vsel,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [2:0]        o_dbg_state
);

  // Start handshake: w=1 means idle; s is sampled only while w=1, and an
  // accepted start drops w on the next cycle until the instruction retires.
  state_t       r_state;
  state_t       w_next;
  logic [2:0]   r_opcode;
  logic [1:0]   r_op;
  logic [2:0]   w_class_raw;
  instr_class_t w_class;

  risc_instr_class u_class (
    .i_opcode (r_opcode),
    .i_op     (r_op),
    .o_class  (w_class_raw)
  );

  assign w_class     = instr_class_t'(w_class_raw);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_opcode <= '0;
      r_op     <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_WAIT) && s) begin
        r_opcode <= opcode;
        r_op     <= op;
      end
    end
  end

  always_comb begin
    w_next = S_WAIT;
    case (r_state)
      S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (w_class)
          CL_MOV_IMM:         w_next = S_WR_IMM;
          CL_MOV_REG, CL_MVN: w_next = S_RD_B;
          CL_ALU2, CL_CMP:    w_next = S_RD_A;
          default:            w_next = S_WAIT;
        endcase
      end
      S_WR_IMM: w_next = S_WAIT;
      S_RD_A:   w_next = S_RD_B;
      S_RD_B:   w_next = S_EXEC;
      S_EXEC:   w_next = class_sets_flags(w_class) ? S_WAIT : S_WR_RES;
      S_WR_RES: w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  // Output decode uses only the state register and the latched class.
  always_comb begin
    w     = 1'b0;
    nsel  = '0;
    vsel  = '0;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WR_IMM: begin
        nsel  = NSEL_W'(NSEL_RN);
        vsel  = VSEL_W'(VSEL_IMM);
        write = 1'b1;
      end
      S_RD_A: begin
        nsel  = NSEL_W'(NSEL_RN);
        loada = 1'b1;
      end
      S_RD_B: begin
        nsel  = NSEL_W'(NSEL_RM);
        loadb = 1'b1;
      end
      S_EXEC: begin
        asel = class_zero_a(w_class);
        if (class_sets_flags(w_class)) loads = 1'b1;
        else                           loadc = 1'b1;
      end
      S_WR_RES: begin
        nsel  = NSEL_W'(NSEL_RD);
        vsel  = VSEL_W'(VSEL_C);
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_datapath_ctrl.sv
// Bench for risc_datapath_ctrl: table of instructions with known latency,
// hand-written reset/back-to-back sequences and random instruction streams.
module tb_risc_datapath_ctrl;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [2:0] dbg_state;

  risc_datapath_ctrl #(.VSEL_W(2), .NSEL_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .opcode      (opcode),
    .op          (op),
    .w           (w),
    .nsel        (nsel),
    .vsel        (vsel),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed output packet: {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel}
  logic [12:0] obs;
  assign obs = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel};

  int n_vec = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] pk(input logic w_, input logic [2:0] ns, input logic [1:0] vs,
                                     input logic wr, input logic la, input logic lb,
                                     input logic lc, input logic ls, input logic as_);
    return {w_, ns, vs, wr, la, lb, lc, ls, as_, 1'b0};
  endfunction

  logic [12:0] idle_pk;
  logic [12:0] busy_pk;

  // Reference model: the micro-step list of one instruction, cycle 1 onward.
  function automatic void model_push(input logic [2:0] opc, input logic [1:0] o);
    logic is_mov, is_alu, imm, movreg, legal, uses_a, flags, zero_a;
    is_mov = (opc == 3'b110);
    is_alu = (opc == 3'b101);
    imm    = is_mov && (o == 2'b10);
    movreg = is_mov && (o == 2'b00);
    legal  = imm || movreg || is_alu;
    uses_a = is_alu && (o != 2'b11);
    flags  = is_alu && (o == 2'b01);
    zero_a = movreg || (is_alu && (o == 2'b11));
    exp_q.push_back(pk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
    if (imm) begin
      exp_q.push_back(pk(0, 3'b001, 2'b10, 1, 0, 0, 0, 0, 0));
    end else if (legal) begin
      if (uses_a) exp_q.push_back(pk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(pk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0));
      exp_q.push_back(pk(0, 3'b000, 2'b00, 0, 0, 0, !flags, flags, zero_a));
      if (!flags) exp_q.push_back(pk(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0));
    end
    exp_q.push_back(pk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [12:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h (t=%0t)", name, obs, exp, $time);
    end else if ($countones({loada, loadb, loadc, write}) > 1) begin
      n_err++;
      $display("FAIL %s onehot: strobes got %b expected at most one high", name,
               {loada, loadb, loadc, write});
    end
  endtask

  // driver: called at a negedge while idle; returns at the negedge where w is back
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           input int exp_lat_in, input string name);
    int lat;
    int exp_lat;
    logic [12:0] e;
    exp_q.delete();
    model_push(opc, o);
    exp_lat = (exp_lat_in < 0) ? exp_q.size() : exp_lat_in;
    s = 1'b1; opcode = opc; op = o;
    @(negedge clk);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = idle_pk;
      check(name, e);
      if (w === 1'b1) begin
        lat = c;
        break;
      end
      s = 1'($urandom); opcode = 3'($urandom); op = 2'($urandom);
      @(negedge clk);
    end
    s = 1'b0;
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
    end
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    idle_pk = pk(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
    busy_pk = pk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{3'b110, 2'b10, 3};
    tbl[1] = '{3'b110, 2'b00, 5};
    tbl[2] = '{3'b101, 2'b00, 6};
    tbl[3] = '{3'b101, 2'b01, 5};
    tbl[4] = '{3'b101, 2'b10, 6};
    tbl[5] = '{3'b101, 2'b11, 5};
    tbl[6] = '{3'b111, 2'b00, 2};
    tbl[7] = '{3'b110, 2'b01, 2};
    tbl[8] = '{3'b000, 2'b11, 2};
    tbl[9] = '{3'b110, 2'b11, 2};

    // reset held with s high
    rst_n = 1'b0; s = 1'b1; opcode = 3'b110; op = 2'b10;
    repeat (2) begin
      @(negedge clk);
      check("reset", idle_pk);
    end
    rst_n = 1'b1;
    run_instr(3'b110, 2'b10, 3, "post_reset");

    // table of instructions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d_idle", i), idle_pk);
      run_instr(tbl[i].opc, tbl[i].op, tbl[i].lat, $sformatf("tbl%0d", i));
    end

    // reset during S_RD_B of ADD
    @(negedge clk);
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    @(negedge clk); s = 1'b0;
    check("midrst_dec", busy_pk);
    @(negedge clk);
    check("midrst_rda", pk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    check("midrst_rdb", pk(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_abort", idle_pk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_quiet", idle_pk);
    end

    // s held high: back-to-back CMPs, w high exactly one cycle between them
    exp_q.delete();
    model_push(3'b101, 2'b01);
    model_push(3'b101, 2'b01);
    s = 1'b1; opcode = 3'b101; op = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("b2b_cmp", exp_q.pop_front());
    end
    s = 1'b0;

    // random instruction stream with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [2:0] r_opc;
      logic [1:0] r_op;
      int sel;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_gap", idle_pk);
      end
      sel = $urandom_range(0, 3);
      case (sel)
        0:       r_opc = 3'b110;
        1, 3:    r_opc = 3'b101;
        default: r_opc = 3'($urandom);
      endcase
      r_op = 2'($urandom);
      run_instr(r_opc, r_op, -1, $sformatf("rand%0d_%b_%b", i, r_opc, r_op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
